// File: rtl/md_unit_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
// The EX stage (master) issues ops and reads back busy and HI/LO.
interface md_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, rs_val, rt_val, input busy, hi, lo);
    modport slave  (input start, op, rs_val, rt_val, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; a down-counter models the
// op latency and HI/LO are written from the latched operands on the final edge.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef struct packed {
        logic        is_div;
        logic        is_uns;
        logic [31:0] a;
        logic [31:0] b;
    } md_req_t;

    md_req_t       req;
    logic [CW-1:0] cnt;
    logic [31:0]   hi;
    logic [31:0]   lo;
    logic          start_md;
    logic          idle;

    assign idle     = (cnt == '0);
    assign start_md = bus.start && (bus.op <= OP_DIVU);
    assign bus.busy = start_md || !idle;
    assign bus.hi   = hi;
    assign bus.lo   = lo;

    // Multiply: sign-extending to 64 bits makes the low 64 product bits the signed result.
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;

    assign ext_a = req.is_uns ? {32'd0, req.a} : {{32{req.a[31]}}, req.a};
    assign ext_b = req.is_uns ? {32'd0, req.b} : {{32{req.b[31]}}, req.b};
    assign prod  = ext_a * ext_b;

    // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_zero;

    assign neg_a    = !req.is_uns && req.a[31];
    assign neg_b    = !req.is_uns && req.b[31];
    assign mag_a    = neg_a ? (~req.a + 32'd1) : req.a;
    assign mag_b    = neg_b ? (~req.b + 32'd1) : req.b;
    assign div_zero = (req.b == 32'd0);
    assign div_b    = div_zero ? 32'd1 : mag_b;
    assign uq       = mag_a / div_b;
    assign ur       = mag_a % div_b;
    assign quot     = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
    assign rem      = neg_a ? (~ur + 32'd1) : ur;

    always_ff @(posedge clk) begin
        if (!reset) begin
            req <= '0;
            cnt <= '0;
            hi  <= '0;
            lo  <= '0;
        end else if (idle) begin
            if (start_md) begin
                req.is_div <= bus.op[1];
                req.is_uns <= bus.op[0];
                req.a      <= bus.rs_val;
                req.b      <= bus.rt_val;
                cnt        <= bus.op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end else if (bus.start && bus.op == OP_MTHI) begin
                hi <= bus.rs_val;
            end else if (bus.start && bus.op == OP_MTLO) begin
                lo <= bus.rs_val;
            end
        end else begin
            // Any start while running is dropped; decode stalls on busy.
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                if (!req.is_div) begin
                    hi <= prod[63:32];
                    lo <= prod[31:0];
                end else if (!div_zero) begin
                    hi <= rem;
                    lo <= quot;
                end
            end
        end
    end

    logic unused_op_const;
    assign unused_op_const = (OP_MULT != 3'd0);
endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: latency, results, divide-by-zero, ignored starts, reset abort.
module tb_md_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    md_unit_if bus ();

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Present an op for one edge; busy is checked combinationally in the issue cycle.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag, input logic exp_busy);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.rs_val = a; bus.rt_val = b;
        #1 chk({tag, "_busy_issue"}, 64'(bus.busy), 64'(exp_busy));
        @(posedge clk);
        #1 bus.start = 1'b0; bus.op = 3'd7;
    endtask

    // Count negedges with busy high after the issue edge; bounded.
    task automatic wait_idle(input string tag, input int exp_n);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (!bus.busy || n > 200) break;
            n++;
        end
        chk({tag, "_busy_len"}, 64'(n), 64'(exp_n));
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 3'd7; bus.rs_val = '0; bus.rt_val = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_hi", 64'(bus.hi), 64'h0);
        chk("rst_lo", 64'(bus.lo), 64'h0);
        chk("rst_busy", 64'(bus.busy), 64'h0);

        // MULT -3 * 5
        issue(3'd0, 32'hFFFF_FFFD, 32'd5, "mult", 1'b1);
        wait_idle("mult", 5);
        chk("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(bus.lo), 64'hFFFF_FFF1);

        // MULTU 0xFFFFFFFF * 2
        issue(3'd1, 32'hFFFF_FFFF, 32'd2, "multu", 1'b1);
        wait_idle("multu", 5);
        chk("multu_hi", 64'(bus.hi), 64'h1);
        chk("multu_lo", 64'(bus.lo), 64'hFFFF_FFFE);

        // DIV -7 / 2
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, "div", 1'b1);
        wait_idle("div", 10);
        chk("div_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        chk("div_lo", 64'(bus.lo), 64'hFFFF_FFFD);

        // MTHI then DIVU by zero leaves HI/LO alone
        issue(3'd4, 32'h1234, 32'd0, "mthi", 1'b0);
        @(negedge clk);
        chk("mthi_hi", 64'(bus.hi), 64'h1234);
        issue(3'd3, 32'd9, 32'd0, "divz", 1'b1);
        wait_idle("divz", 10);
        chk("divz_hi", 64'(bus.hi), 64'h1234);
        chk("divz_lo", 64'(bus.lo), 64'hFFFF_FFFD);

        // op 6 has no effect
        issue(3'd6, 32'h5555, 32'h5555, "nop", 1'b0);
        @(negedge clk);
        chk("nop_hi", 64'(bus.hi), 64'h1234);
        chk("nop_lo", 64'(bus.lo), 64'hFFFF_FFFD);

        // Signed overflow corner
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "ovf", 1'b1);
        wait_idle("ovf", 10);
        chk("ovf_hi", 64'(bus.hi), 64'h0);
        chk("ovf_lo", 64'(bus.lo), 64'h8000_0000);

        // DIV 100/7 with an MTLO presented at cnt=4
        issue(3'd2, 32'd100, 32'd7, "divmt", 1'b1);
        repeat (7) @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd5; bus.rs_val = 32'hAAAA;
        @(posedge clk);
        #1 bus.start = 1'b0; bus.op = 3'd7;
        wait_idle("divmt", 3);
        chk("divmt_hi", 64'(bus.hi), 64'd2);
        chk("divmt_lo", 64'(bus.lo), 64'd14);

        // New op presented on the finishing edge issues one edge later
        issue(3'd1, 32'd3, 32'd4, "b2b", 1'b1);
        repeat (5) @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd0; bus.rs_val = 32'd5; bus.rt_val = 32'd6;
        @(negedge clk);
        chk("b2b_first_lo", 64'(bus.lo), 64'd12);
        chk("b2b_first_hi", 64'(bus.hi), 64'd0);
        chk("b2b_busy_held", 64'(bus.busy), 64'h1);
        @(posedge clk);
        #1 bus.start = 1'b0; bus.op = 3'd7;
        wait_idle("b2b", 5);
        chk("b2b_second_lo", 64'(bus.lo), 64'd30);

        // Reset aborts an in-flight MULT at cnt=3
        issue(3'd0, 32'd7, 32'd9, "abort", 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("abort_hi", 64'(bus.hi), 64'h0);
        chk("abort_lo", 64'(bus.lo), 64'h0);
        chk("abort_busy", 64'(bus.busy), 64'h0);
        repeat (6) @(negedge clk);
        chk("abort_lo_late", 64'(bus.lo), 64'h0);
        issue(3'd0, 32'd2, 32'd3, "post", 1'b1);
        wait_idle("post", 5);
        chk("post_lo", 64'(bus.lo), 64'd6);
        chk("post_hi", 64'(bus.hi), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
